// File: rtl/led_pattern_engine_if.sv
// Signal bundle between the LED mode selector, the pattern engine and the LED pins.
// The pause input exists only when LED_PAUSE_EN is defined.
interface led_pattern_engine_if #(
    parameter int LED_W = 8
);
    logic [4:0]       compareNUM;
    logic [1:0]       pattern_sel;
`ifdef LED_PAUSE_EN
    logic             pause;
`endif
    logic [LED_W-1:0] led;
    logic             step;

`ifdef LED_PAUSE_EN
    modport master (output compareNUM, output pattern_sel, output pause, input led, input step);
    modport slave  (input compareNUM, input pattern_sel, input pause, output led, output step);
`else
    modport master (output compareNUM, output pattern_sel, input led, input step);
    modport slave  (input compareNUM, input pattern_sel, output led, output step);
`endif
endinterface

// File: rtl/led_pattern_engine.sv
// LED animation engine: a free-running counter tapped at compareNUM paces walk/bounce/count/fill
// patterns. Defining LED_PAUSE_EN adds a pause input that freezes the animation.
module led_pattern_engine #(
    parameter int CNT_W = 22,
    parameter int LED_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    led_pattern_engine_if.slave  bus
);
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [4:0]       idx_r;
    logic [1:0]       sel_r;
    logic             dir_r;
    logic             dir_next_s;
    logic [LED_W-1:0] led_r;
    logic [LED_W-1:0] led_next_s;
    logic [LED_W-1:0] shifted_s;
    logic             step_r;
    logic             step_next_s;
    logic [31:0]      rise_s;
    logic             tick_s;
    logic             pause_s;

`ifdef LED_PAUSE_EN
    assign pause_s = bus.pause;
`else
    assign pause_s = 1'b0;
`endif

    assign cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

    // Bits that go 0->1 on the coming edge, padded so any 5-bit tap indexes in range.
    always_comb begin
        rise_s              = 32'd0;
        rise_s[CNT_W-1:0]   = ~cnt_r & cnt_next_s;
    end

    // Tick only for a valid, stable tap; an unknown selector falls to the else branch.
    always_comb begin
        tick_s = 1'b0;
        if (({27'd0, bus.compareNUM} < 32'(CNT_W)) && (bus.compareNUM == idx_r) && !pause_s) begin
            tick_s = rise_s[bus.compareNUM];
        end else begin
            tick_s = 1'b0;
        end
    end

    // State register: counter, tap/pattern history, LEDs, bounce direction and step pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r  <= {CNT_W{1'b0}};
            idx_r  <= 5'd0;
            sel_r  <= 2'b00;
            led_r  <= {LED_W{1'b0}};
            dir_r  <= DIR_LEFT;
            step_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            idx_r  <= bus.compareNUM;
            sel_r  <= bus.pattern_sel;
            led_r  <= led_next_s;
            dir_r  <= dir_next_s;
            step_r <= step_next_s;
        end
    end

    // Next-state logic: a pattern change wins over a tick and restarts from an empty display.
    always_comb begin
        led_next_s  = led_r;
        dir_next_s  = dir_r;
        step_next_s = 1'b0;
        shifted_s   = {LED_W{1'b0}};
        if (bus.pattern_sel != sel_r) begin
            led_next_s = {LED_W{1'b0}};
            dir_next_s = DIR_LEFT;
        end else if (tick_s) begin
            step_next_s = 1'b1;
            case (sel_r)
                2'b00: begin
                    if (led_r == {LED_W{1'b0}}) begin
                        led_next_s = {{(LED_W-1){1'b0}}, 1'b1};
                    end else begin
                        led_next_s = {led_r[LED_W-2:0], led_r[LED_W-1]};
                    end
                end
                2'b01: begin
                    if (led_r == {LED_W{1'b0}}) begin
                        led_next_s = {{(LED_W-1){1'b0}}, 1'b1};
                        dir_next_s = DIR_LEFT;
                    end else if (dir_r == DIR_LEFT) begin
                        shifted_s  = {led_r[LED_W-2:0], 1'b0};
                        led_next_s = shifted_s;
                        dir_next_s = shifted_s[LED_W-1] ? DIR_RIGHT : DIR_LEFT;
                    end else begin
                        shifted_s  = {1'b0, led_r[LED_W-1:1]};
                        led_next_s = shifted_s;
                        dir_next_s = shifted_s[0] ? DIR_LEFT : DIR_RIGHT;
                    end
                end
                2'b10: begin
                    led_next_s = led_r + {{(LED_W-1){1'b0}}, 1'b1};
                end
                2'b11: begin
                    if (&led_r) begin
                        led_next_s = {LED_W{1'b0}};
                    end else begin
                        led_next_s = {led_r[LED_W-2:0], 1'b1};
                    end
                end
                default: begin
                    led_next_s = led_r;
                end
            endcase
        end else begin
            step_next_s = 1'b0;
        end
    end

    assign bus.led  = led_r;
    assign bus.step = step_r;
endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine (CNT_W=6, LED_W=8): a step-count model plus directed checks.
module tb_led_pattern_engine;
    localparam int CNT_W = 6;
    localparam int LED_W = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    led_pattern_engine_if #(.LED_W(LED_W)) bus ();

    led_pattern_engine #(.CNT_W(CNT_W), .LED_W(LED_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: counter value, steps since the pattern last restarted, previous tap/pattern.
    int         cnt_m, k_m, idx_m, edge_n;
    logic [1:0] sel_m;
    logic       step_m;

    function automatic bit will_tick();
        int i;
        i = int'(bus.compareNUM);
`ifdef LED_PAUSE_EN
        if (bus.pause) return 1'b0;
`endif
        if (i >= CNT_W || i != idx_m) return 1'b0;
        return ((cnt_m + 1) % (1 << (i + 1))) == (1 << i);
    endfunction

    function automatic logic [LED_W-1:0] pat(input logic [1:0] s, input int k);
        logic [LED_W-1:0] r;
        int p, pos, n;
        r = '0;
        if (k == 0) return r;
        case (s)
            2'd0: r[(k - 1) % LED_W] = 1'b1;
            2'd1: begin
                p   = (k - 1) % (2 * (LED_W - 1));
                pos = (p < LED_W) ? p : 2 * (LED_W - 1) - p;
                r[pos] = 1'b1;
            end
            2'd2: r = LED_W'(k % (1 << LED_W));
            default: begin
                n = k % (LED_W + 1);
                r = LED_W'((32'd1 << n) - 32'd1);
            end
        endcase
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        if (reset) begin
            cnt_m  <= 0;
            k_m    <= 0;
            idx_m  <= 0;
            sel_m  <= 2'd0;
            step_m <= 1'b0;
            edge_n <= 0;
        end else begin
            if (bus.pattern_sel != sel_m) begin
                sel_m  <= bus.pattern_sel;
                k_m    <= 0;
                step_m <= 1'b0;
            end else if (will_tick()) begin
                k_m    <= k_m + 1;
                step_m <= 1'b1;
            end else begin
                step_m <= 1'b0;
            end
            idx_m  <= int'(bus.compareNUM);
            cnt_m  <= (cnt_m + 1) % (1 << CNT_W);
            edge_n <= edge_n + 1;
        end
    end

    always @(negedge clk) begin : compare
        if (!reset) begin
            chk("model_led", bus.led, pat(sel_m, k_m));
            chk("model_step", bus.step, step_m);
        end
    end

    task automatic wait_step(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.step && n < 300);
        chk({nm, "_step_seen"}, bus.step, 1'b1);
    endtask

    task automatic wait_tick_edge();
        int n;
        n = 0;
        while (!will_tick() && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("tick_edge_found", will_tick(), 1'b1);
    endtask

    logic [7:0] walk_exp   [3]  = '{8'h01, 8'h02, 8'h04};
    int         walk_edge  [3]  = '{4, 12, 20};
    logic [7:0] bounce_exp [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [7:0] fill_exp   [10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                    8'h00, 8'h01};

    initial begin : stimulus
        logic [LED_W-1:0] frozen;
        int e1, e2;
        reset           = 1'b1;
        bus.compareNUM  = 5'd2;
        bus.pattern_sel = 2'b00;
`ifdef LED_PAUSE_EN
        bus.pause       = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset_led", bus.led, 8'h00);
        chk("reset_step", bus.step, 1'b0);
        reset = 1'b0;

        for (int s = 0; s < 3; s++) begin
            wait_step("walk");
            chk("walk_edge", edge_n, walk_edge[s]);
            chk("walk_led", bus.led, walk_exp[s]);
        end
        while (edge_n < 21) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_led", bus.led, 8'h00);
        chk("async_reset_step", bus.step, 1'b0);

        @(negedge clk);
        bus.compareNUM  = 5'd0;
        bus.pattern_sel = 2'b01;
        reset           = 1'b0;
        for (int s = 0; s < 16; s++) begin
            wait_step("bounce");
            chk("bounce_led", bus.led, bounce_exp[s]);
        end

        bus.pattern_sel = 2'b11;
        for (int s = 0; s < 10; s++) begin
            wait_step("fill");
            chk("fill_led", bus.led, fill_exp[s]);
        end

        bus.pattern_sel = 2'b10;
        for (int s = 1; s <= 257; s++) begin
            wait_step("count");
            if (s == 255) chk("count_ff", bus.led, 8'hFF);
            if (s == 256) chk("count_wrap", bus.led, 8'h00);
            if (s == 257) chk("count_01", bus.led, 8'h01);
        end

        bus.pattern_sel = 2'b00;
        repeat (2) wait_step("walk2");
        chk("walk2_led", bus.led, 8'h02);
        @(negedge clk);
        wait_tick_edge();
        bus.pattern_sel = 2'b10;
        @(negedge clk);
        chk("patchg_led", bus.led, 8'h00);
        chk("patchg_step", bus.step, 1'b0);
        wait_step("patchg_next");
        chk("patchg_next_led", bus.led, 8'h01);

        bus.compareNUM = 5'd2;
        wait_step("speed2");
        @(negedge clk);
        wait_tick_edge();
        bus.compareNUM = 5'd3;
        @(negedge clk);
        chk("speedchg_step", bus.step, 1'b0);
        wait_step("speed3a");
        e1 = edge_n;
        wait_step("speed3b");
        e2 = edge_n;
        chk("speed3_interval", e2 - e1, 16);

        bus.compareNUM = 5'd31;
        @(negedge clk);
        frozen = bus.led;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            chk("badtap_step", bus.step, 1'b0);
            chk("badtap_led", bus.led, frozen);
        end

`ifdef LED_PAUSE_EN
        bus.compareNUM = 5'd2;
        wait_step("prepause");
        bus.pause = 1'b1;
        frozen    = bus.led;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("pause_step", bus.step, 1'b0);
            chk("pause_led", bus.led, frozen);
        end
        bus.pause = 1'b0;
        wait_step("postpause");
        chk("postpause_phase", cnt_m % 8, 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
